coverage_accumulator: RTL and testbench

//  Upstream producer of the 30-bit coverage sum that the fuzz-loop stall/watchdog monitor consumes.

---
 rtl/coverage_accumulator_if.sv | 32 +++
 rtl/coverage_accumulator.sv | 136 +++++++++++++
 tb/tb_coverage_accumulator.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/coverage_accumulator_if.sv
// rtl/coverage_accumulator_if.sv - coverage-hit stream and round-control bundle
// Optional dup_cnt member is present when COV_ACC_DUP_CNT_EN is defined.
interface coverage_accumulator_if #(
  parameter int IDX_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx;
  logic             clear_req;
  logic             clear_busy;
  logic             new_hit;
  logic [29:0]      cov_sum;
`ifdef COV_ACC_DUP_CNT_EN
  logic [31:0]      dup_cnt;
`endif

  modport master (
    output in_valid, in_idx, clear_req,
`ifdef COV_ACC_DUP_CNT_EN
    input  dup_cnt,
`endif
    input  in_ready, clear_busy, new_hit, cov_sum
  );

  modport slave (
    input  in_valid, in_idx, clear_req,
`ifdef COV_ACC_DUP_CNT_EN
    output dup_cnt,
`endif
    output in_ready, clear_busy, new_hit, cov_sum
  );
endinterface

// File: rtl/coverage_accumulator.sv
// rtl/coverage_accumulator.sv - distinct coverage-index counter over a RAM seen-bitmap
// Optional duplicate-hit counter enabled by defining COV_ACC_DUP_CNT_EN.
module coverage_accumulator #(
  parameter int IDX_W  = 16,
  parameter int WORD_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  coverage_accumulator_if.slave acc
);
  localparam int BIT_W  = $clog2(WORD_W);
  localparam int ADDR_W = IDX_W - BIT_W;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_DRAIN} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              in_ready_q, clear_busy_q, new_hit_q;
  logic [29:0]       cov_sum_q;
  logic              s1_valid_q;
  logic [ADDR_W-1:0] s1_word_q;
  logic [BIT_W-1:0]  s1_bit_q;
  logic [WORD_W-1:0] rdata_q;
  logic              fwd_valid_q;
  logic [ADDR_W-1:0] fwd_word_q;
  logic [WORD_W-1:0] fwd_data_q;
  logic [WORD_W-1:0] mem [DEPTH];

  logic              accept, s1_new, s1_dup, mem_we;
  logic [WORD_W-1:0] s1_data, s1_wdata, mem_wdata;
  logic [ADDR_W-1:0] mem_waddr;

  assign accept = acc.in_valid && in_ready_q;

  // The RAM read for S1 was issued while the previous entry's write was still in flight.
  always_comb begin
    s1_data = rdata_q;
    if (fwd_valid_q && (fwd_word_q == s1_word_q)) s1_data = rdata_q | fwd_data_q;
    s1_new    = s1_valid_q && !s1_data[s1_bit_q];
    s1_dup    = s1_valid_q && s1_data[s1_bit_q];
    s1_wdata  = s1_data | (WORD_W'(1) << s1_bit_q);
    mem_we    = s1_new;
    mem_waddr = s1_word_q;
    mem_wdata = s1_wdata;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_q;
      mem_wdata = '0;
    end
    if (reset) mem_we = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (accept) begin
      rdata_q   <= mem[acc.in_idx[IDX_W-1:BIT_W]];
      s1_word_q <= acc.in_idx[IDX_W-1:BIT_W];
      s1_bit_q  <= acc.in_idx[BIT_W-1:0];
    end
    if (s1_new) begin
      fwd_word_q <= s1_word_q;
      fwd_data_q <= s1_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_CLEAR;
      ptr_q        <= '0;
      in_ready_q   <= 1'b0;
      clear_busy_q <= 1'b1;
      new_hit_q    <= 1'b0;
      cov_sum_q    <= '0;
      s1_valid_q   <= 1'b0;
      fwd_valid_q  <= 1'b0;
    end else begin
      s1_valid_q  <= accept;
      fwd_valid_q <= s1_new;
      new_hit_q   <= s1_new;
      if (s1_new) cov_sum_q <= cov_sum_q + 30'd1;
      case (state_q)
        ST_CLEAR: begin
          // Zeroing every sweep cycle lets a hit retired on the way in stay visible for one cycle.
          cov_sum_q <= '0;
          ptr_q     <= ptr_q + ADDR_W'(1);
          if (&ptr_q) begin
            state_q      <= ST_RUN;
            in_ready_q   <= 1'b1;
            clear_busy_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (acc.clear_req) begin
            in_ready_q <= 1'b0;
            if (accept) begin
              state_q <= ST_DRAIN;
            end else begin
              state_q      <= ST_CLEAR;
              clear_busy_q <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          state_q      <= ST_CLEAR;
          clear_busy_q <= 1'b1;
        end
        default: begin
          state_q      <= ST_CLEAR;
          in_ready_q   <= 1'b0;
          clear_busy_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef COV_ACC_DUP_CNT_EN
  logic [31:0] dup_cnt_q;
  always_ff @(posedge clock) begin
    if (reset || (state_q == ST_CLEAR)) begin
      dup_cnt_q <= '0;
    end else if (s1_dup && (dup_cnt_q != 32'hFFFF_FFFF)) begin
      dup_cnt_q <= dup_cnt_q + 32'd1;
    end
  end
  assign acc.dup_cnt = dup_cnt_q;
`else
  logic unused_dup;
  assign unused_dup = s1_dup;
`endif

  assign acc.in_ready   = in_ready_q;
  assign acc.clear_busy = clear_busy_q;
  assign acc.new_hit    = new_hit_q;
  assign acc.cov_sum    = cov_sum_q;
endmodule

// File: tb/tb_coverage_accumulator.sv
// tb/tb_coverage_accumulator.sv - scoreboard bench for coverage_accumulator (IDX_W=16, WORD_W=32)
module tb_coverage_accumulator;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_q[$];
  int   exp_sum = 0;
  int   exp_dup = 0;
  bit   seen [65536];

  coverage_accumulator_if #(.IDX_W(16)) acc_if ();
  coverage_accumulator #(.IDX_W(16), .WORD_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .acc   (acc_if.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (!reset && acc_if.new_hit) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_new_hit actual=1 expected=0 cov_sum=%0d", acc_if.cov_sum);
      end else begin
        check("new_hit_cov_sum", 32'(acc_if.cov_sum), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 65536; i++) seen[i] = 1'b0;
    exp_sum = 0;
    exp_dup = 0;
  endtask

  task automatic model_hit(input logic [15:0] idx);
    if (!seen[idx]) begin
      seen[idx] = 1'b1;
      exp_sum++;
      exp_q.push_back(exp_sum);
    end else begin
      exp_dup++;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!acc_if.in_ready && n < 5000) begin
      @(negedge clock);
      n++;
    end
    if (!acc_if.in_ready) check("in_ready_timeout", 32'(acc_if.in_ready), 32'd1);
  endtask

  task automatic send(input logic [15:0] idx);
    wait_ready();
    acc_if.in_valid = 1'b1;
    acc_if.in_idx   = idx;
    model_hit(idx);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    acc_if.in_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic settle(input string tag);
    idle(4);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_cov_sum"}, 32'(acc_if.cov_sum), 32'(exp_sum));
`ifdef COV_ACC_DUP_CNT_EN
    check({tag, "_dup_cnt"}, acc_if.dup_cnt, 32'(exp_dup));
`endif
  endtask

  // Counts negedges from now until clear_busy is low.
  task automatic sweep_cycles(output int n, input bit poke);
    n = 0;
    do begin
      @(negedge clock);
      n++;
      acc_if.clear_req = (poke && n == 500);
    end while (acc_if.clear_busy && n < 5000);
    acc_if.clear_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(acc_if.in_ready), 32'd0);
    check({tag, "_clear_busy"}, 32'(acc_if.clear_busy), 32'd1);
    check({tag, "_new_hit"}, 32'(acc_if.new_hit), 32'd0);
    check({tag, "_cov_sum"}, 32'(acc_if.cov_sum), 32'd0);
  endtask

  task automatic do_clear(input bit with_idx, input logic [15:0] idx, input bit poke);
    int n;
    wait_ready();
    acc_if.clear_req = 1'b1;
    if (with_idx) begin
      acc_if.in_valid = 1'b1;
      acc_if.in_idx   = idx;
      model_hit(idx);
    end
    @(negedge clock);
    acc_if.clear_req = 1'b0;
    acc_if.in_valid  = 1'b0;
    model_clear();
    if (with_idx) begin
      check("drain_in_ready", 32'(acc_if.in_ready), 32'd0);
      check("drain_clear_busy", 32'(acc_if.clear_busy), 32'd0);
    end else begin
      check("clear_busy_rise", 32'(acc_if.clear_busy), 32'd1);
    end
    sweep_cycles(n, poke);
    check("clear_sweep_len", 32'(n), with_idx ? 32'd2049 : 32'd2048);
    check("clear_in_ready", 32'(acc_if.in_ready), 32'd1);
    check("clear_cov_sum", 32'(acc_if.cov_sum), 32'd0);
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    acc_if.in_valid  = 1'b0;
    acc_if.in_idx    = '0;
    acc_if.clear_req = 1'b0;
    model_clear();

    // Reset and initial sweep
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
    sweep_cycles(n, 1'b0);
    check("init_sweep_len", 32'(n), 32'd2048);
    check("init_in_ready", 32'(acc_if.in_ready), 32'd1);
    check("init_cov_sum", 32'(acc_if.cov_sum), 32'd0);

    // Same word, then a repeat of the first bit
    send(16'h0005); send(16'h0006); send(16'h0005);
    settle("t2");

    // Forwarding within one word, then repeats must not recount
    do_clear(1'b0, 16'h0, 1'b0);
    send(16'h0040); send(16'h0041);
    settle("t3a");
    send(16'h0040); send(16'h0041);
    settle("t3b");
    send(16'h0077); send(16'h0077); send(16'hFFFF);
    settle("t3c");

    // clear_req with a concurrent accepted index
    do_clear(1'b1, 16'h1234, 1'b0);
    send(16'h1234);
    settle("t4");

    // clear_req during the sweep is ignored
    do_clear(1'b0, 16'h0, 1'b1);
    settle("t4b");

    // Random indices over an 8-bit space
    for (int i = 0; i < 10000; i++) send(16'($urandom_range(255)));
    settle("t5");

    // Reset partway through a sweep
    acc_if.clear_req = 1'b1;
    @(negedge clock);
    acc_if.clear_req = 1'b0;
    repeat (101) @(negedge clock);
    reset = 1'b1;
    exp_q.delete();
    model_clear();
    @(negedge clock);
    check_reset_outputs("t6a");
    reset = 1'b0;
    sweep_cycles(n, 1'b0);
    check("t6a_sweep_len", 32'(n), 32'd2048);

    // Reset while S1 holds an accepted index
    send(16'h0777);
    acc_if.in_valid = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    model_clear();
    @(negedge clock);
    check_reset_outputs("t6b");
    reset = 1'b0;
    sweep_cycles(n, 1'b0);
    check("t6b_sweep_len", 32'(n), 32'd2048);
    send(16'h0777);
    settle("t6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
